pwm_duty_capture: RTL and testbench
===================================

Name: pwm_duty_capture

Overview:
- Receive-side counterpart of the signed PWM generator.
- Measures an incoming PWM waveform and reports its period, high time and signed duty. The duty uses the same signed convention as the generator: high time minus half period.
- Used in closed-loop benches and hardware self-check to recover the duty actually driven onto the half-bridge, including stuck-high and stuck-low (0 %/100 %) conditions.
- Runs on the 100 MHz system clock, one sample per clock.

Parameters:
- W, 16, width of the period and high-time counters; signed duty output is also W bits.
- M, 1000, nominal PWM period in clocks; HALF = M/2 is the saturated duty magnitude reported on timeout.
- TIMEOUT, 4000, clocks without a rising edge before stuck is declared. Requires M < TIMEOUT < 2^W.
- DG, 4, deglitch length in clocks. Used only with PWMCAP_DEGLITCH_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- pwm_in  in  1  asynchronous PWM input
- valid  out  1  one-cycle pulse: outputs updated this cycle
- period  out  W  measured rising-to-rising period in clocks; 0 on timeout
- high_time  out  W  clocks high within that period; 0 on timeout
- duty  out  W signed  high_time - (period>>1); ±HALF on timeout
- timeout  out  1  level: 1 while in STUCK, cleared by the next rising edge

Behaviour:
- Synchronizer
  - pwm_in always passes through a 2-FF synchronizer.
  - Rising edge = synced level now 1, previous 0.
  - Edge-to-output latency is 3 clocks from the pwm_in transition.
- Counters
  - cnt and hcnt are both loaded with 1 on a rising edge.
  - Otherwise cnt increments every clock; hcnt increments when the synced level is 1.
  - cnt saturates at TIMEOUT and never wraps.
- States
  - IDLE (after reset)
    - Rising edge -> MEAS; no output.
    - cnt == TIMEOUT -> STUCK.
  - MEAS
    - Rising edge -> register period = cnt, high_time = hcnt, duty = hcnt - (cnt>>1) (arithmetic in W+1 bits, then truncated; it always fits).
    - Pulse valid; restart counters; stay in MEAS.
    - cnt == TIMEOUT -> STUCK.
  - STUCK
    - On entry: valid pulse, timeout = 1, period = 0, high_time = 0, duty = +HALF if synced level is 1 else -HALF.
    - Repeats that output every TIMEOUT clocks while no edge arrives (cnt reloads to 1 at each repeat).
    - Rising edge -> MEAS, timeout = 0, counters restart, no valid that cycle.
- Simultaneous events: a rising edge in the same cycle cnt reaches TIMEOUT is treated as an edge (edge wins).
- Reset
  - Values: valid = 0, period = 0, high_time = 0, duty = 0, timeout = 0, state = IDLE, synchronizer flops = 0.
  - Mid-measurement: the partial period is discarded. The first valid after reset requires two rising edges.
- Outputs hold their value between valid pulses.

Optional Feature:
- Macro PWMCAP_DEGLITCH_EN.
- Defined:
  - The synced signal feeds a filter whose output changes only after DG consecutive equal samples.
  - Pulses or gaps shorter than DG clocks are ignored.
  - Edge-to-output latency becomes 3+DG clocks.
  - period is unaffected in steady state.
- Undefined: no filter; the synchronizer output is used directly and the DG parameter is unused.

Decomposition:
- Package pwm_cap_pkg:
  - state enum {IDLE, MEAS, STUCK}
  - function sat_duty(level, M) returning ±M/2
- Sub-module pwm_cap_deglitch(clk, rst, din, dout):
  - DG-length stable-sample filter.
  - Instantiated only under PWMCAP_DEGLITCH_EN.

Test Plan:
- Period 1000, high 750, 5 periods -> first valid after the 2nd edge; then period = 1000, high_time = 750, duty = +250 on every edge.
- Period 1000, high 500 generated by PwmSigned with duty 0 -> duty = 0, period = 1000.
- Input held high after the last edge -> valid with timeout = 1, duty = +500, period = 0, TIMEOUT clocks after that edge; repeats every 4000 clocks. A new rising edge clears timeout and causes no valid; the following edge gives a normal measurement.
- Input held low from reset -> after 4000 clocks valid, duty = -500, timeout = 1.
- Reset asserted mid-period -> all outputs 0 next cycle, no valid until two further edges.
- With PWMCAP_DEGLITCH_EN, DG = 4: 2-clock glitch inserted in the low phase -> measurements unchanged (period = 1000). Without the macro, the same stimulus produces a short-period valid.

Source files
------------

// File: rtl/pwm_cap_pkg.sv
// Shared types and helpers for the PWM duty capture block.
package pwm_cap_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMeas,
    StStuck
  } cap_state_e;

  // Saturated duty reported while the input is stuck: +M/2 when high, -M/2 when low.
  function automatic int sat_duty(input logic level, input int unsigned m);
    int half;
    half = int'(m / 2);
    return level ? half : -half;
  endfunction

endpackage

// File: rtl/pwm_cap_deglitch.sv
// Stable-sample filter: dout follows din only after DG consecutive differing samples.
module pwm_cap_deglitch #(
  parameter int unsigned DG = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CntW = $clog2(DG + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dout_q, dout_d;

  always_comb begin
    cnt_d  = '0;
    dout_d = dout_q;
    if (din != dout_q) begin
      if (cnt_q == CntW'(DG - 1)) begin
        dout_d = din;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      dout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures period, high time and signed duty of an incoming PWM waveform.
// Optional input deglitch filter enabled by defining PWMCAP_DEGLITCH_EN.
module pwm_duty_capture
  import pwm_cap_pkg::*;
#(
  parameter int unsigned W       = 16,
  parameter int unsigned M       = 1000,
  parameter int unsigned TIMEOUT = 4000,
  parameter int unsigned DG      = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pwm_in,
  output logic                valid,
  output logic [W-1:0]        period,
  output logic [W-1:0]        high_time,
  output logic signed [W-1:0] duty,
  output logic                timeout
);

  localparam logic [W-1:0] TimeoutW = W'(TIMEOUT);

  logic sync1_q, sync2_q;
  logic level, level_q, rise;

  cap_state_e          state_q, state_d;
  logic [W-1:0]        cnt_q, cnt_d;
  logic [W-1:0]        hcnt_q, hcnt_d;
  logic                valid_q, valid_d;
  logic [W-1:0]        period_q, period_d;
  logic [W-1:0]        high_q, high_d;
  logic signed [W-1:0] duty_q, duty_d;
  logic                timeout_q, timeout_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      level_q <= level;
    end
  end

`ifdef PWMCAP_DEGLITCH_EN
  pwm_cap_deglitch #(
    .DG(DG)
  ) u_deglitch (
    .clk (clk),
    .rst (rst),
    .din (sync2_q),
    .dout(level)
  );
`else
  assign level = sync2_q;
`endif

  assign rise = level & ~level_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + W'(1);
    hcnt_d    = level ? hcnt_q + W'(1) : hcnt_q;
    valid_d   = 1'b0;
    period_d  = period_q;
    high_d    = high_q;
    duty_d    = duty_q;
    timeout_d = timeout_q;

    // An edge takes priority over a coincident timeout.
    if (rise) begin
      cnt_d  = W'(1);
      hcnt_d = W'(1);
      unique case (state_q)
        StIdle: state_d = StMeas;
        StMeas: begin
          valid_d  = 1'b1;
          period_d = cnt_q;
          high_d   = hcnt_q;
          // hcnt <= cnt, so the true difference always fits in W signed bits.
          duty_d   = hcnt_q - (cnt_q >> 1);
        end
        StStuck: begin
          state_d   = StMeas;
          timeout_d = 1'b0;
        end
        default: state_d = StIdle;
      endcase
    end else if (cnt_q == TimeoutW) begin
      state_d   = StStuck;
      valid_d   = 1'b1;
      timeout_d = 1'b1;
      period_d  = '0;
      high_d    = '0;
      duty_d    = W'(sat_duty(level, M));
      cnt_d     = W'(1);
      hcnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      valid_q   <= 1'b0;
      period_q  <= '0;
      high_q    <= '0;
      duty_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      valid_q   <= valid_d;
      period_q  <= period_d;
      high_q    <= high_d;
      duty_q    <= duty_d;
      timeout_q <= timeout_d;
    end
  end

  assign valid     = valid_q;
  assign period    = period_q;
  assign high_time = high_q;
  assign duty      = duty_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Directed bench for pwm_duty_capture; expectations follow PWMCAP_DEGLITCH_EN when defined.
module tb_pwm_duty_capture;

  localparam int unsigned DG = 4;
`ifdef PWMCAP_DEGLITCH_EN
  localparam int Lat = 3 + DG;
  localparam bit Filt = 1'b1;
`else
  localparam int Lat = 3;
  localparam bit Filt = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pwm_in = 1'b0;
  logic               valid;
  logic [15:0]        period;
  logic [15:0]        high_time;
  logic signed [15:0] duty;
  logic               timeout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vcount = 0;
  int last_period, last_high, last_duty, last_timeout, last_vcyc;

  pwm_duty_capture #(
    .W      (16),
    .M      (1000),
    .TIMEOUT(4000),
    .DG     (DG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pwm_in   (pwm_in),
    .valid    (valid),
    .period   (period),
    .high_time(high_time),
    .duty     (duty),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount++;
      last_period  = int'(period);
      last_high    = int'(high_time);
      last_duty    = int'(duty);
      last_timeout = int'(timeout);
      last_vcyc    = cyc;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_cycles(input logic v, input int n);
    pwm_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pwm_period(input int hi, input int lo);
    drive_cycles(1'b1, hi);
    drive_cycles(1'b0, lo);
  endtask

  task automatic wait_vcount(input string tag, input int target, input int limit);
    int k;
    k = 0;
    while (vcount < target && k < limit) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(tag, vcount, target);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_high"}, int'(high_time), 0);
    check({tag, "_duty"}, int'(duty), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    int n0, n1, n2, n3, c0, v1, v2;

    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst = 1'b0;

    // 1000/750 waveform: first valid only on the second rising edge.
    n0 = vcount;
    pwm_period(750, 250);
    check("first_edge_no_valid", vcount, n0);
    c0 = cyc;
    drive_cycles(1'b1, 750);
    check("first_valid_count", vcount, n0 + 1);
    check("edge_latency", last_vcyc - c0, Lat);
    check("p750_first_period", last_period, 1000);
    check("p750_first_high", last_high, 750);
    check("p750_first_duty", last_duty, 250);
    drive_cycles(1'b0, 250);
    repeat (3) pwm_period(750, 250);
    check("p750_valid_count", vcount, n0 + 4);
    check("p750_period", last_period, 1000);
    check("p750_high", last_high, 750);
    check("p750_duty", last_duty, 250);
    check("p750_timeout", last_timeout, 0);

    // 50 % waveform: the first new edge closes the last 750-high period.
    n0 = vcount;
    repeat (3) pwm_period(500, 500);
    check("p500_valid_count", vcount, n0 + 3);
    check("p500_period", last_period, 1000);
    check("p500_high", last_high, 500);
    check("p500_duty", last_duty, 0);

    // Stuck high after a final rising edge.
    n0 = vcount;
    pwm_in = 1'b1;
    wait_vcount("pre_stuck_meas", n0 + 1, 20);
    check("pre_stuck_high", last_high, 500);
    v1 = last_vcyc;
    wait_vcount("stuck_high_seen", n0 + 2, 4100);
    check("stuck_high_delay", last_vcyc - v1, 4000);
    check("stuck_high_timeout", last_timeout, 1);
    check("stuck_high_duty", last_duty, 500);
    check("stuck_high_period", last_period, 0);
    check("stuck_high_hightime", last_high, 0);
    v2 = last_vcyc;
    wait_vcount("stuck_repeat_seen", n0 + 3, 4100);
    check("stuck_repeat_delay", last_vcyc - v2, 4000);
    check("stuck_repeat_duty", last_duty, 500);

    // Recovery: the edge out of stuck clears timeout silently.
    drive_cycles(1'b0, 300);
    n1 = vcount;
    drive_cycles(1'b1, 250);
    check("recover_timeout_clear", int'(timeout), 0);
    check("recover_no_valid", vcount, n1);
    drive_cycles(1'b0, 750);
    drive_cycles(1'b1, 10);
    wait_vcount("recover_meas_seen", n1 + 1, 20);
    check("recover_period", last_period, 1000);
    check("recover_high", last_high, 250);
    check("recover_duty", last_duty, -250);
    check("recover_timeout", last_timeout, 0);

    // Reset in the low phase discards the partial period.
    drive_cycles(1'b1, 740);
    drive_cycles(1'b0, 400);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_zero_outputs("mid_reset");
    rst = 1'b0;
    n2 = vcount;
    drive_cycles(1'b0, 100);
    pwm_period(750, 250);
    check("post_reset_edge1_no_valid", vcount, n2);
    drive_cycles(1'b1, 10);
    wait_vcount("post_reset_edge2_valid", n2 + 1, 20);
    check("post_reset_period", last_period, 1000);

    // Two-clock glitch in the low phase.
    n3 = vcount;
    drive_cycles(1'b1, 740);
    drive_cycles(1'b0, 50);
    drive_cycles(1'b1, 2);
    drive_cycles(1'b0, 198);
    drive_cycles(1'b1, 10);
    if (Filt) begin
      wait_vcount("glitch_valid_count", n3 + 1, 20);
      check("glitch_period", last_period, 1000);
      check("glitch_high", last_high, 750);
      check("glitch_duty", last_duty, 250);
    end else begin
      wait_vcount("glitch_valid_count", n3 + 2, 20);
      check("glitch_period", last_period, 200);
      check("glitch_high", last_high, 2);
      check("glitch_duty", last_duty, -98);
    end
    check("glitch_total_valids", vcount - n3, Filt ? 1 : 2);

    // Held low from reset.
    rst = 1'b1;
    pwm_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n0 = vcount;
    wait_vcount("stuck_low_seen", n0 + 1, 4100);
    check("stuck_low_duty", last_duty, -500);
    check("stuck_low_timeout", last_timeout, 1);
    check("stuck_low_period", last_period, 0);
    check("stuck_low_level", int'(timeout), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
